// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared widths, padding constant and state type for the SHA-256 padder
package sha256_pkg;

   localparam int block_width = 512;
   localparam int word_width  = 32;
   localparam int len_width   = 64;

   // Word holding only the FIPS 180-4 end-of-message marker bit
   localparam logic [word_width-1:0] pad_word = 32'h8000_0000;

   typedef enum logic [1:0] {
      FILL,
      EMIT,
      EXTRA
   } state_e;

endpackage

// File: rtl/sha256_pad_word.sv
// rtl/sha256_pad_word.sv - masks the final message word and inserts the 0x80 marker
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [word_width-1:0] data,
   input  logic [2:0]            bytes,
   output logic [word_width-1:0] word,
   output logic                  needs_next_word
);

   // Keep the leading valid bytes, put 0x80 right after them; a full word pushes the marker out
   always_comb begin
      word            = pad_word;
      needs_next_word = 1'b0;
      case (bytes)
         3'd0:    word = pad_word;
         3'd1:    word = {data[31:24], 24'h80_0000};
         3'd2:    word = {data[31:16], 16'h8000};
         3'd3:    word = {data[31:8],  8'h80};
         default: begin
            word            = data;
            needs_next_word = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - collects message words into one 512-bit block and emits padded blocks
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int len_width_p = len_width,
   parameter     id_p        = "inv"
)
(
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   en_i,
   input  logic                   v_i,
   input  logic [word_width-1:0]  data_i,
   input  logic                   last_i,
   input  logic [2:0]             bytes_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [block_width-1:0] data_o,
   output logic                   last_o,
   input  logic                   yumi_i
);

   localparam logic [len_width_p-1:0] word_bits = len_width_p'(word_width);

   state_e                   state, state_next;
   logic [0:15][31:0]        blk;
   logic [0:15][31:0]        extra_blk;
   logic [3:0]               idx;
   logic [3:0]               idx_inc;
   logic [len_width_p-1:0]   len;
   logic [len_width_p-1:0]   len_add;
   logic [len_width_p-1:0]   len_new;
   logic                     pend80;
   logic                     need_extra;
   logic                     last_blk;
   logic [4:0]               p;
   logic [word_width-1:0]    pad_w;
   logic                     pad_next;
   logic                     accept;
   logic                     take;
   logic                     block_done;

   sha256_pad_word u_pad_word (
      .data            (data_i),
      .bytes           (bytes_i),
      .word            (pad_w),
      .needs_next_word (pad_next)
   );

   assign ready_o = reset_n_i & en_i & (state == FILL);
   assign v_o     = (state != FILL);
   assign accept  = v_i & ready_o;
   assign take    = yumi_i & v_o & en_i;
   assign data_o  = blk;
   assign last_o  = last_blk;
   assign idx_inc = idx + 4'd1;

   // A block closes on the message's last word or when a full word lands in slot 15
   assign block_done = accept & (last_i | ((bytes_i == 3'd4) & (idx == 4'd15)));

   // Length update and first free slot after the marker for the final word
   always_comb begin
      len_add      = '0;
      len_add[5:0] = pad_next ? 6'd32 : {bytes_i, 3'b000};
      len_new      = len + len_add;
      p            = {1'b0, idx} + 5'd1 + {4'b0000, pad_next};
   end

   // Trailing block used when the length field did not fit after the marker
   always_comb begin
      extra_blk     = '0;
      extra_blk[0]  = pend80 ? pad_word : '0;
      extra_blk[14] = len[63:32];
      extra_blk[15] = len[31:0];
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         FILL:    if (block_done) state_next = EMIT;
         EMIT:    if (take) state_next = need_extra ? EXTRA : FILL;
         EXTRA:   if (take) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) state <= FILL;
      else            state <= state_next;
   end

   // Block buffer, word index, length counter and padding flags
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         blk        <= '0;
         idx        <= '0;
         len        <= '0;
         pend80     <= 1'b0;
         need_extra <= 1'b0;
         last_blk   <= 1'b0;
      end else if (accept) begin
         if (!last_i) begin
            // Partial non-last words are dropped without effect
            if (bytes_i == 3'd4) begin
               blk[idx] <= data_i;
               len      <= len + word_bits;
               idx      <= idx_inc;
               last_blk <= 1'b0;
            end
         end else begin
            blk[idx] <= pad_w;
            len      <= len_new;
            if (pad_next) begin
               if (idx != 4'd15) blk[idx_inc] <= pad_word;
               else              pend80       <= 1'b1;
            end
            if (p <= 5'd14) begin
               blk[14]  <= len_new[63:32];
               blk[15]  <= len_new[31:0];
               last_blk <= 1'b1;
            end else begin
               need_extra <= 1'b1;
               last_blk   <= 1'b0;
            end
         end
      end else if (take) begin
         if ((state == EMIT) && need_extra) begin
            blk      <= extra_blk;
            last_blk <= 1'b1;
         end else begin
            // Buffer must be all-zero so untouched slots become the zero fill of the next block
            blk        <= '0;
            idx        <= '0;
            pend80     <= 1'b0;
            need_extra <= 1'b0;
            last_blk   <= 1'b0;
            if (last_blk) len <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized self-checking bench for sha256_msg_padder
module tb_sha256_msg_padder;

   logic         clk = 1'b0;
   logic         reset_n_i;
   logic         en_i;
   logic         v_i;
   logic [31:0]  data_i;
   logic         last_i;
   logic [2:0]   bytes_i;
   logic         ready_o;
   logic         v_o;
   logic [511:0] data_o;
   logic         last_o;
   logic         yumi_i;

   int checks   = 0;
   int failures = 0;

   localparam logic [511:0] abc_blk = {32'h6162_6380, 448'h0, 32'h0000_0018};

   sha256_msg_padder #(.len_width_p(64), .id_p("inv")) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n_i),
      .en_i      (en_i),
      .v_i       (v_i),
      .data_i    (data_i),
      .last_i    (last_i),
      .bytes_i   (bytes_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .last_o    (last_o),
      .yumi_i    (yumi_i)
   );

   always #5 clk = ~clk;

   // Producer protocol: only full words may be sent without last
   always @(posedge clk)
      if (reset_n_i && v_i && ready_o && !last_i)
         assert (bytes_i == 3'd4) else $error("protocol: non-last word with bytes_i=%0d", bytes_i);

   // Reference: FIPS 180-4 padding of a byte string, cut into 64-byte blocks
   function automatic void build_expected(input byte unsigned msg[$],
                                          output logic [511:0] blks[$],
                                          output bit lasts[$]);
      byte unsigned     pb[$];
      longint unsigned  bits;
      logic [511:0]     b;
      int               nblk;
      pb   = msg;
      bits = longint'(msg.size()) * 8;
      pb.push_back(8'h80);
      while ((pb.size() % 64) != 56) pb.push_back(8'h00);
      for (int i = 7; i >= 0; i--) pb.push_back(8'(bits >> (8 * i)));
      blks.delete();
      lasts.delete();
      nblk = pb.size() / 64;
      for (int bi = 0; bi < nblk; bi++) begin
         b = '0;
         for (int k = 0; k < 64; k++) b[511 - 8 * k -: 8] = pb[64 * bi + k];
         blks.push_back(b);
         lasts.push_back(bi == nblk - 1);
      end
   endfunction

   task automatic run_msg(input string name, input int nbytes, input bit zero_tail,
                          input int stall_pct, input int en_off_pct);
      byte unsigned msg[$];
      logic [511:0] exp_blk[$];
      bit           exp_last[$];
      logic [31:0]  wd[$];
      logic [2:0]   wb[$];
      bit           wl[$];
      logic [31:0]  w;
      int           nfull, rem, wi, cyc, word_in_blk;
      bit           expect_vo;
      for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
      build_expected(msg, exp_blk, exp_last);
      nfull = nbytes / 4;
      rem   = nbytes % 4;
      for (int i = 0; i < nfull; i++) begin
         for (int k = 0; k < 4; k++) w[31 - 8 * k -: 8] = msg[4 * i + k];
         wd.push_back(w);
         wb.push_back(3'd4);
         wl.push_back((i == nfull - 1) && (rem == 0) && !zero_tail);
      end
      if (rem != 0 || zero_tail || nbytes == 0) begin
         w = $urandom;
         for (int k = 0; k < rem; k++) w[31 - 8 * k -: 8] = msg[4 * nfull + k];
         wd.push_back(w);
         wb.push_back(3'(rem));
         wl.push_back(1'b1);
      end
      wi = 0; cyc = 0; word_in_blk = 0; expect_vo = 1'b0;
      while ((wi < wd.size() || exp_blk.size() > 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         v_i    = 1'b0;
         yumi_i = 1'b0;
         en_i   = ($urandom_range(0, 99) >= en_off_pct);
         #1;
         if (expect_vo) begin
            checks++;
            if (v_o !== 1'b1) begin
               failures++;
               $display("FAIL %s latency v_o=%b required=1", name, v_o);
            end
            expect_vo = 1'b0;
         end
         if (v_o) begin
            checks++;
            if (exp_blk.size() == 0) begin
               failures++;
               $display("FAIL %s extra_block got=%h required=none", name, data_o);
            end else begin
               if (data_o !== exp_blk[0] || last_o !== exp_last[0]) begin
                  failures++;
                  $display("FAIL %s block got=%h last=%b required=%h last=%b",
                           name, data_o, last_o, exp_blk[0], exp_last[0]);
               end
               checks++;
               if (ready_o !== 1'b0) begin
                  failures++;
                  $display("FAIL %s ready_in_emit got=%b required=0", name, ready_o);
               end
               if (en_i && $urandom_range(0, 99) >= stall_pct) begin
                  yumi_i = 1'b1;
                  void'(exp_blk.pop_front());
                  void'(exp_last.pop_front());
               end
            end
         end else if (ready_o && wi < wd.size() && $urandom_range(0, 99) >= stall_pct) begin
            v_i     = 1'b1;
            data_i  = wd[wi];
            bytes_i = wb[wi];
            last_i  = wl[wi];
            word_in_blk++;
            if (wl[wi] || word_in_blk == 16) begin
               expect_vo   = 1'b1;
               word_in_blk = 0;
            end
            wi++;
         end
      end
      checks++;
      if (wi < wd.size() || exp_blk.size() > 0) begin
         failures++;
         $display("FAIL %s timeout words_left=%0d blocks_left=%0d required=0/0",
                  name, wd.size() - wi, exp_blk.size());
      end
      @(negedge clk);
      v_i = 1'b0; yumi_i = 1'b0; en_i = 1'b1;
      #1;
      checks++;
      if (v_o !== 1'b0 || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL %s idle_after v_o=%b ready_o=%b required=0/1", name, v_o, ready_o);
      end
   endtask

   task automatic test_reset;
      reset_n_i = 1'b0; en_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
      data_i = '0; last_i = 1'b0; bytes_i = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (v_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_state v_o=%b last_o=%b ready_o=%b data_o=%h required=0/0/0/0",
                  v_o, last_o, ready_o, data_o);
      end
      @(negedge clk);
      reset_n_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_release ready_o=%b required=1", ready_o);
      end
   endtask

   task automatic test_abc_backpressure;
      logic [511:0] held;
      @(negedge clk);
      en_i = 1'b1; v_i = 1'b1; data_i = 32'h6162_6300; bytes_i = 3'd3; last_i = 1'b1;
      @(negedge clk);
      v_i = 1'b0;
      #1;
      checks++;
      if (v_o !== 1'b1 || data_o !== abc_blk || last_o !== 1'b1) begin
         failures++;
         $display("FAIL abc v_o=%b last_o=%b data_o=%h required=1/1/%h", v_o, last_o, data_o, abc_blk);
      end
      held = abc_blk;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         v_i = 1'b1; data_i = $urandom; bytes_i = 3'd4; last_i = 1'b0;
         #1;
         checks++;
         if (v_o !== 1'b1 || data_o !== held || last_o !== 1'b1 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL hold v_o=%b last_o=%b ready_o=%b data_o=%h required=1/1/0/%h",
                     v_o, last_o, ready_o, data_o, held);
         end
      end
      @(negedge clk);
      v_i = 1'b0; yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
      #1;
      checks++;
      if (v_o !== 1'b0 || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL abc_take v_o=%b ready_o=%b required=0/1", v_o, ready_o);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         v_i = 1'b1; data_i = $urandom; bytes_i = 3'd4; last_i = 1'b0;
      end
      @(negedge clk);
      v_i = 1'b0; reset_n_i = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_ready ready_o=%b required=0", ready_o);
      end
      @(negedge clk);
      reset_n_i = 1'b1;
      v_i = 1'b1; data_i = 32'h6162_6300; bytes_i = 3'd3; last_i = 1'b1;
      @(negedge clk);
      v_i = 1'b0;
      #1;
      checks++;
      if (v_o !== 1'b1 || data_o !== abc_blk || last_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_abc v_o=%b last_o=%b data_o=%h required=1/1/%h",
                  v_o, last_o, data_o, abc_blk);
      end
      // Reset while a block is being offered drops it
      @(negedge clk);
      reset_n_i = 1'b0;
      @(negedge clk);
      reset_n_i = 1'b1;
      #1;
      checks++;
      if (v_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0) begin
         failures++;
         $display("FAIL reset_emit v_o=%b last_o=%b data_o=%h required=0/0/0", v_o, last_o, data_o);
      end
   endtask

   task automatic test_empty;        run_msg("empty",   0, 1'b0, 0, 0);  endtask
   task automatic test_55_bytes;     run_msg("b55",    55, 1'b0, 0, 0);  endtask
   task automatic test_56_bytes;     run_msg("b56",    56, 1'b0, 20, 0); endtask
   task automatic test_64_bytes;     run_msg("b64",    64, 1'b0, 20, 0); endtask
   task automatic test_64_zero_tail; run_msg("b64z",   64, 1'b1, 20, 0); endtask
   task automatic test_60_61_bytes;
      run_msg("b60", 60, 1'b0, 0, 0);
      run_msg("b61", 61, 1'b0, 0, 0);
      run_msg("b60z", 60, 1'b1, 0, 0);
   endtask
   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) run_msg("b2b", $urandom_range(0, 80), 1'($urandom), 0, 0);
   endtask
   task automatic test_random;
      for (int i = 0; i < 25; i++) run_msg("rand", $urandom_range(0, 140), 1'($urandom), 30, 15);
   endtask

   initial begin
      test_reset();
      test_abc_backpressure();
      test_empty();
      test_55_bytes();
      test_56_bytes();
      test_64_bytes();
      test_64_zero_tail();
      test_60_61_bytes();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 node. It accepts a message as a stream of 32-bit big-endian words with a last/byte-count tag.
- It emits complete 512-bit padded blocks in FIPS 180-4 form: 0x80 marker, zero fill, and a 64-bit bit-length field.
- Blocks go out over a valid/yumi handshake to the block assembler/core.
- It holds exactly one block buffer. There is no overlap between emitting one block and filling the next.

Parameters:
- len_width_p, 64: width of the message bit-length counter; must be 64 for SHA-256.
- id_p, "inv": node identifier; passed through only, no logic effect.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  synchronous reset, active-low.
- en_i  in  1  block enable; when 0, both handshakes are gated off and state is frozen.
- v_i  in  1  input word valid.
- data_i  in  32  message word; first byte in [31:24].
- last_i  in  1  this word ends the message.
- bytes_i  in  3  valid bytes in this word, 0..4. 0 is legal only with last_i.
- ready_o  out  1  padder accepts a word this cycle.
- v_o  out  1  data_o holds a valid block.
- data_o  out  512  block; word 0 in [511:480], word 15 in [31:0].
- last_o  out  1  this is the final block of the message.
- yumi_i  in  1  consumer takes the block this cycle; legal only when v_o=1.

Behaviour:
- Reset: synchronous and active-low; clk_i is the only clock.
- While reset_n_i=0 at a rising edge:
  - state goes to FILL; index, length and buffer clear to 0; the pending-0x80 flag clears.
  - v_o=0, last_o=0, data_o=0.
- ready_o is 0 in any cycle where reset_n_i=0.
- Reset mid-message or mid-emit discards everything; no partial block is ever emitted.
- States:
  - FILL: ready_o = en_i; v_o = 0.
  - EMIT: v_o = 1; data_o is the main block.
  - EXTRA: v_o = 1; data_o is the trailing length block.
  - ready_o = 0 in EMIT and EXTRA, so there is no input buffering.
- Accept = v_i & ready_o. Take = yumi_i & v_o & en_i.
- Non-last word with bytes_i=4 (in FILL):
  - store it at index idx; len += 32; idx += 1.
  - if idx was 15, go to EMIT with last_o=0.
- Non-last word with bytes_i!=4: the word is ignored. A bench protocol assertion flags this.
- Last word with n = bytes_i; let p = next free word index after the padding marker:
  - n=0: word[idx] = 0x80000000; p = idx+1.
  - n=1..3: word[idx] keeps the top n bytes, byte n = 0x80, lower bytes zero; len += 8n; p = idx+1.
  - n=4: word[idx] = data_i; len += 32.
    - if idx<15: word[idx+1] = 0x80000000.
    - if idx=15: set pend80 (the 0x80 word goes into the extra block).
    - p = idx+2.
  - All words at or above p are zero.
  - p<=14: words 14/15 = len[63:32]/len[31:0]; go to EMIT with last_o=1.
  - p>=15: go to EMIT with last_o=0 and set need_extra.
- EMIT on take:
  - need_extra=1: go to EXTRA.
  - otherwise go to FILL; clear the buffer and idx; clear len if last_o was 1.
- EXTRA block contents:
  - word 0 = 0x80000000 if pend80, else 0;
  - words 1..13 = 0;
  - words 14/15 = len.
- EXTRA: last_o=1. On take, go to FILL and clear len, idx, pend80 and need_extra.
- Latency: v_o rises in the cycle after the accept of the 16th word or the last word.
- Next-block ready_o rises in the cycle after the take of the block.
- data_o and last_o are registered and stay stable while v_o=1 and no take occurs.
- Length arithmetic is modulo 2^64 and wraps silently.
- en_i=0: no accept, no take, and all registers hold. v_o/data_o keep their values.

Decomposition:
- Package sha256_pkg holds:
  - block_width = 512, word_width = 32, len_width = 64;
  - pad_word constant 0x80000000;
  - the state enum {FILL, EMIT, EXTRA}.
- One combinational sub-module, sha256_pad_word, with inputs data, bytes and outputs masked word, needs_next_word.
- The top-level padder holds the state machine, buffer, index and length counter.

Test Plan:
- "abc": a single word 0x61626300, bytes=3, last=1 -> one block:
  - word0 = 0x61626380, words1-14 = 0, word15 = 0x00000018, last_o=1;
  - v_o rises in the cycle after the accept.
- Empty message: bytes=0, last=1 -> one block with word0 = 0x80000000, word15 = 0, all other words 0, last_o=1.
- 55 bytes: 13 full words plus word 13 with bytes=3, last -> one block:
  - word13 has low byte 0x80;
  - word14 = 0, word15 = 0x000001B8; last_o=1.
- 56 bytes: 14 full words, last on the 14th -> block 1 then block 2:
  - block 1: word14 = 0x80000000, word15 = 0, last_o=0;
  - block 2: all zero except word15 = 0x000001C0, last_o=1.
- 64 bytes: 16 full words, last on the 16th -> block 1 then block 2:
  - block 1: data only, last_o=0;
  - block 2: word0 = 0x80000000, word15 = 0x00000200, last_o=1.
- Backpressure and reset:
  - hold yumi_i=0 for 5 cycles -> v_o, data_o and last_o stable; ready_o=0; v_i ignored.
  - after 7 accepted words, pulse reset_n_i=0 for 1 cycle, then send "abc" -> output identical to the "abc" case (length 0x18).
